// File: rtl/clock_div_multi.sv
// clock_div_multi: multi-channel programmable 50%-duty clock divider.
// Each channel divides clk_in by 2*D, where D = max(active divisor, 1),
// and emits a one-cycle tick in the cycle its divided clock rises.
// Divisors load into a shadow register and are applied only at the end
// of a full period (falling wrap), on disable, or on sync, so a retune
// never produces a short or partial pulse.
//
// Ports:
//   clk_in    input clock, all state on its rising edge
//   rst_n     asynchronous active-low reset
//   en        per-channel run enable
//   sync      one-cycle strobe restarting all enabled channels in phase
//   div_load  per-channel strobe capturing its divisor slice
//   div_in    divisor values, channel i at [i*WIDTH +: WIDTH]
//   clk_out   divided clocks (registered)
//   tick      one-cycle pulse in the cycle clk_out[i] rises (registered)
//   pending   a loaded divisor is waiting to be applied (registered)
module clock_div_multi #(
    parameter int unsigned NCH         = 2,
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEFAULT_DIV = 1
) (
    input  logic                   clk_in,
    input  logic                   rst_n,
    input  logic [NCH-1:0]         en,
    input  logic                   sync,
    input  logic [NCH-1:0]         div_load,
    input  logic [NCH*WIDTH-1:0]   div_in,
    output logic [NCH-1:0]         clk_out,
    output logic [NCH-1:0]         tick,
    output logic [NCH-1:0]         pending
);

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic [WIDTH-1:0] r_cnt;
        logic [WIDTH-1:0] r_active;
        logic [WIDTH-1:0] r_shadow;
        logic             r_clk;
        logic             r_tick;
        logic             r_pend;

        logic [WIDTH-1:0] w_cnt_nxt;
        logic [WIDTH-1:0] w_active_nxt;
        logic [WIDTH-1:0] w_shadow_nxt;
        logic             w_clk_nxt;
        logic             w_tick_nxt;
        logic             w_pend_nxt;
        logic             w_apply;
        logic [WIDTH-1:0] w_slice;
        logic [WIDTH-1:0] w_last;
        logic             w_wrap;

        assign w_slice = div_in[gi*WIDTH +: WIDTH];

        // Terminal count D-1; a zero divisor behaves as 1 (terminal 0)
        assign w_last = (r_active == '0) ? '0 : (r_active - WIDTH'(1));
        assign w_wrap = (r_cnt == w_last);

        // Next-state: disable > sync > wrap > count, then divisor bookkeeping
        always_comb begin
            w_cnt_nxt    = r_cnt + WIDTH'(1);
            w_clk_nxt    = r_clk;
            w_tick_nxt   = 1'b0;
            w_apply      = 1'b0;
            w_active_nxt = r_active;
            w_shadow_nxt = r_shadow;
            w_pend_nxt   = r_pend;

            if (!en[gi]) begin
                w_cnt_nxt = '0;
                w_clk_nxt = 1'b0;
                w_apply   = 1'b1;
            end else if (sync) begin
                w_cnt_nxt = '0;
                w_clk_nxt = 1'b0;
                w_apply   = 1'b1;
            end else if (w_wrap) begin
                w_cnt_nxt  = '0;
                w_clk_nxt  = ~r_clk;
                w_tick_nxt = ~r_clk;
                // Only the high->low wrap closes a full period
                w_apply    = r_clk;
            end

            // A load coinciding with an application point is used directly
            if (w_apply) begin
                if (div_load[gi]) begin
                    w_active_nxt = w_slice;
                    w_shadow_nxt = w_slice;
                end else begin
                    w_active_nxt = r_shadow;
                end
                w_pend_nxt = 1'b0;
            end else if (div_load[gi]) begin
                w_shadow_nxt = w_slice;
                w_pend_nxt   = 1'b1;
            end
        end

        // Channel state register
        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt    <= '0;
                r_active <= DEF_DIV;
                r_shadow <= DEF_DIV;
                r_clk    <= 1'b0;
                r_tick   <= 1'b0;
                r_pend   <= 1'b0;
            end else begin
                r_cnt    <= w_cnt_nxt;
                r_active <= w_active_nxt;
                r_shadow <= w_shadow_nxt;
                r_clk    <= w_clk_nxt;
                r_tick   <= w_tick_nxt;
                r_pend   <= w_pend_nxt;
            end
        end

        assign clk_out[gi] = r_clk;
        assign tick[gi]    = r_tick;
        assign pending[gi] = r_pend;
    end

endmodule

// File: tb/tb_clock_div_multi.sv
// Testbench for clock_div_multi: directed vector table, hand-written corner
// sequences and randomized stimulus against a period-position model.
module tb_clock_div_multi;

    localparam int unsigned NCH         = 2;
    localparam int unsigned WIDTH       = 8;
    localparam int unsigned DEFAULT_DIV = 1;

    logic                 clk_in = 1'b0;
    logic                 rst_n;
    logic [NCH-1:0]       en;
    logic                 sync;
    logic [NCH-1:0]       div_load;
    logic [NCH*WIDTH-1:0] div_in;
    logic [NCH-1:0]       clk_out;
    logic [NCH-1:0]       tick;
    logic [NCH-1:0]       pending;

    int total = 0;
    int bad   = 0;

    always #5 clk_in = ~clk_in;

    clock_div_multi #(
        .NCH(NCH), .WIDTH(WIDTH), .DEFAULT_DIV(DEFAULT_DIV)
    ) dut (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .en      (en),
        .sync    (sync),
        .div_load(div_load),
        .div_in  (div_in),
        .clk_out (clk_out),
        .tick    (tick),
        .pending (pending)
    );

    // Model: position within the current period (0..2D-1), active/shadow divisor
    int m_pos [NCH];
    int m_div [NCH];
    int m_sh  [NCH];
    bit m_pend[NCH];

    function automatic int eff(input int d);
        return (d < 1) ? 1 : d;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_pos[i]  = 0;
            m_div[i]  = int'(DEFAULT_DIV);
            m_sh[i]   = int'(DEFAULT_DIV);
            m_pend[i] = 1'b0;
        end
    endtask

    // Advance the model by one clk_in edge using the current inputs
    task automatic model_step();
        for (int i = 0; i < NCH; i++) begin
            int sl;
            bit ap;
            sl = int'(div_in[i*WIDTH +: WIDTH]);
            ap = 1'b0;
            if (!en[i] || sync) begin
                m_pos[i] = 0;
                ap = 1'b1;
            end else begin
                m_pos[i] = m_pos[i] + 1;
                if (m_pos[i] == 2 * eff(m_div[i])) begin
                    m_pos[i] = 0;
                    ap = 1'b1;
                end
            end
            if (ap) begin
                if (div_load[i]) begin
                    m_div[i] = sl;
                    m_sh[i]  = sl;
                end else begin
                    m_div[i] = m_sh[i];
                end
                m_pend[i] = 1'b0;
            end else if (div_load[i]) begin
                m_sh[i]   = sl;
                m_pend[i] = 1'b1;
            end
        end
    endtask

    function automatic logic [NCH-1:0] m_clk();
        logic [NCH-1:0] r;
        for (int i = 0; i < NCH; i++) r[i] = (m_pos[i] >= eff(m_div[i]));
        return r;
    endfunction

    function automatic logic [NCH-1:0] m_tick();
        logic [NCH-1:0] r;
        for (int i = 0; i < NCH; i++) r[i] = (m_pos[i] == eff(m_div[i]));
        return r;
    endfunction

    function automatic logic [NCH-1:0] m_pnd();
        logic [NCH-1:0] r;
        for (int i = 0; i < NCH; i++) r[i] = m_pend[i];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%h want=%h", nm, $time, act, exp);
        end
    endtask

    task automatic drive(input logic [NCH-1:0] e, input logic s,
                         input logic [NCH-1:0] l, input logic [NCH*WIDTH-1:0] d);
        en = e; sync = s; div_load = l; div_in = d;
    endtask

    // One clock with model comparison, sampled 1 time unit after the edge
    task automatic cyc(input string nm);
        model_step();
        @(posedge clk_in);
        #1;
        chk({nm, ".clk_out"}, 32'(clk_out), 32'(m_clk()));
        chk({nm, ".tick"},    32'(tick),    32'(m_tick()));
        chk({nm, ".pending"}, 32'(pending), 32'(m_pnd()));
    endtask

    typedef struct {
        logic [NCH-1:0]       en;
        logic                 sync;
        logic [NCH-1:0]       ld;
        logic [NCH*WIDTH-1:0] div;
        logic [NCH-1:0]       clk;
        logic [NCH-1:0]       tk;
        logic [NCH-1:0]       pd;
    } vec_t;

    vec_t vecs[16];

    initial begin
        vecs[0]  = '{2'b11, 1'b0, 2'b00, 16'h0000, 2'b11, 2'b11, 2'b00};
        vecs[1]  = '{2'b11, 1'b0, 2'b00, 16'h0000, 2'b00, 2'b00, 2'b00};
        vecs[2]  = '{2'b11, 1'b0, 2'b10, 16'h0300, 2'b11, 2'b11, 2'b10};
        vecs[3]  = '{2'b11, 1'b0, 2'b00, 16'h0000, 2'b00, 2'b00, 2'b00};
        vecs[4]  = '{2'b11, 1'b0, 2'b00, 16'h0000, 2'b01, 2'b01, 2'b00};
        vecs[5]  = '{2'b11, 1'b0, 2'b00, 16'h0000, 2'b00, 2'b00, 2'b00};
        vecs[6]  = '{2'b11, 1'b0, 2'b00, 16'h0000, 2'b11, 2'b11, 2'b00};
        vecs[7]  = '{2'b11, 1'b0, 2'b00, 16'h0000, 2'b10, 2'b00, 2'b00};
        vecs[8]  = '{2'b11, 1'b0, 2'b00, 16'h0000, 2'b11, 2'b01, 2'b00};
        vecs[9]  = '{2'b11, 1'b0, 2'b00, 16'h0000, 2'b00, 2'b00, 2'b00};
        vecs[10] = '{2'b01, 1'b0, 2'b00, 16'h0000, 2'b01, 2'b01, 2'b00};
        vecs[11] = '{2'b00, 1'b1, 2'b00, 16'h0000, 2'b00, 2'b00, 2'b00};
        vecs[12] = '{2'b11, 1'b1, 2'b01, 16'h0000, 2'b00, 2'b00, 2'b00};
        vecs[13] = '{2'b11, 1'b0, 2'b00, 16'h0000, 2'b01, 2'b01, 2'b00};
        vecs[14] = '{2'b11, 1'b0, 2'b00, 16'h0000, 2'b00, 2'b00, 2'b00};
        vecs[15] = '{2'b11, 1'b0, 2'b00, 16'h0000, 2'b11, 2'b11, 2'b00};

        // Reset state
        rst_n = 1'b0;
        drive('0, 1'b0, '0, '0);
        model_reset();
        #12;
        chk("reset.clk_out", 32'(clk_out), 32'd0);
        chk("reset.tick",    32'(tick),    32'd0);
        chk("reset.pending", 32'(pending), 32'd0);
        @(posedge clk_in);
        #1;
        rst_n = 1'b1;

        // Directed vector table
        for (int k = 0; k < 16; k++) begin
            drive(vecs[k].en, vecs[k].sync, vecs[k].ld, vecs[k].div);
            model_step();
            @(posedge clk_in);
            #1;
            chk($sformatf("vec%0d.clk_out", k), 32'(clk_out), 32'(vecs[k].clk));
            chk($sformatf("vec%0d.tick", k),    32'(tick),    32'(vecs[k].tk));
            chk($sformatf("vec%0d.pending", k), 32'(pending), 32'(vecs[k].pd));
        end

        // Ch0 div 2, ch1 div 5, then sync: phase alignment
        drive(2'b11, 1'b0, 2'b11, {8'd5, 8'd2});
        cyc("align_load");
        drive(2'b11, 1'b0, 2'b00, '0);
        cyc("align_wait");
        drive(2'b11, 1'b1, 2'b00, '0);
        cyc("align_sync");
        chk("align_sync.zero", 32'(clk_out), 32'd0);
        drive(2'b11, 1'b0, 2'b00, '0);
        for (int k = 0; k < 24; k++) cyc("align_run");

        // Sync with simultaneous load of 4, then double load before the wrap
        drive(2'b11, 1'b1, 2'b11, {8'd4, 8'd4});
        cyc("synld");
        chk("synld.pending0", 32'(pending), 32'd0);
        drive(2'b11, 1'b0, 2'b00, '0);
        for (int k = 0; k < 3; k++) cyc("synld_run");
        drive(2'b11, 1'b0, 2'b01, {8'd0, 8'd6});
        cyc("reload1");
        chk("reload1.pending", 32'(pending[0]), 32'd1);
        drive(2'b11, 1'b0, 2'b01, {8'd0, 8'd2});
        cyc("reload2");
        drive(2'b11, 1'b0, 2'b00, '0);
        for (int k = 0; k < 20; k++) cyc("reload_run");

        // Disable ch0 mid-high phase; ch1 keeps running
        while (!clk_out[0]) cyc("dis_seek");
        drive(2'b10, 1'b0, 2'b00, '0);
        cyc("dis");
        chk("dis.clk0", 32'(clk_out[0]), 32'd0);
        for (int k = 0; k < 4; k++) cyc("dis_run");

        // Long divisor, then asynchronous reset mid-high-phase
        drive(2'b11, 1'b1, 2'b11, {8'd3, 8'd255});
        cyc("long_sync");
        drive(2'b11, 1'b0, 2'b10, {8'd7, 8'd0});
        cyc("long_ld1");
        drive(2'b11, 1'b0, 2'b00, '0);
        for (int k = 0; k < 260; k++) cyc("long_run");
        chk("long.high0", 32'(clk_out[0]), 32'd1);
        @(posedge clk_in);
        #3;
        rst_n = 1'b0;
        #1;
        chk("areset.clk_out", 32'(clk_out), 32'd0);
        chk("areset.tick",    32'(tick),    32'd0);
        chk("areset.pending", 32'(pending), 32'd0);
        model_reset();
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) cyc("post_reset");

        // Randomized stimulus
        for (int k = 0; k < 1500; k++) begin
            logic [NCH-1:0]       e;
            logic [NCH-1:0]       l;
            logic [NCH*WIDTH-1:0] d;
            for (int i = 0; i < NCH; i++) begin
                e[i] = ($urandom_range(9) != 0);
                l[i] = ($urandom_range(14) == 0);
                d[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(7));
            end
            drive(e, ($urandom_range(39) == 0), l, d);
            cyc("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
